// File: rtl/trace_capture_if.sv
// Readout port of the trace recorder: FIFO head {time, value} offered over valid/ready.
// master = recorder side, slave = consumer side.
interface trace_capture_if #(
  parameter int WIDTH    = 3,
  parameter int TS_WIDTH = 16
);
  logic                rd_valid;
  logic                rd_ready;
  logic [WIDTH-1:0]    rd_value;
  logic [TS_WIDTH-1:0] rd_time;

  modport master (output rd_valid, output rd_value, output rd_time, input rd_ready);
  modport slave  (input rd_valid, input rd_value, input rd_time, output rd_ready);
endinterface

// File: rtl/trace_capture.sv
// Logic-trace recorder: timestamps every probe-bus change after arming and queues the
// {time, value} events in a fall-through FIFO. Define TRACE_CAPTURE_TS_SAT_EN to saturate ts.
module trace_capture #(
  parameter int WIDTH    = 3,
  parameter int TS_WIDTH = 16,
  parameter int DEPTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [WIDTH-1:0]           probe,
  trace_capture_if.master            rd,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d;

  logic [WIDTH-1:0]    val_mem  [DEPTH];
  logic [TS_WIDTH-1:0] time_mem [DEPTH];

  logic                arm, push, pop, full, wr_en, drop;
  logic [TS_WIDTH-1:0] push_ts;

  function automatic logic [TS_WIDTH-1:0] ts_inc(input logic [TS_WIDTH-1:0] t);
`ifdef TRACE_CAPTURE_TS_SAT_EN
    return (&t) ? t : t + 1'b1;
`else
    return t + 1'b1;
`endif
  endfunction

  // Capture FSM: decides whether this edge produces an event and with which timestamp.
  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    prev_d  = prev_q;
    arm     = 1'b0;
    push    = 1'b0;
    push_ts = ts_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          arm     = 1'b1;
          push    = 1'b1;
          push_ts = '0;
          prev_d  = probe;
          ts_d    = TS_WIDTH'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (en) begin
          push   = (probe != prev_q);
          prev_d = probe;
          ts_d   = ts_inc(ts_q);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop frees the slot on the same edge, so a full FIFO still accepts a push then.
  always_comb begin
    full    = (count_q == FULL_CNT);
    pop     = (count_q != '0) && rd.rd_ready;
    wr_en   = push && (!full || pop);
    drop    = push && full && !pop;
    count_d = count_q + CW'(wr_en) - CW'(pop);
    ovf_d   = arm ? 1'b0 : (ovf_q | drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ts_q     <= '0;
      prev_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_d;
      prev_q   <= prev_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      val_mem[wr_ptr_q]  <= probe;
      time_mem[wr_ptr_q] <= push_ts;
    end
  end

  // Head is forced to zero when empty so stale storage never shows on the port.
  assign rd.rd_valid = (count_q != '0);
  assign rd.rd_value = rd.rd_valid ? val_mem[rd_ptr_q]  : '0;
  assign rd.rd_time  = rd.rd_valid ? time_mem[rd_ptr_q] : '0;
  assign count       = count_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_trace_capture.sv
// Scoreboard bench for trace_capture: event model on the rising edge, monitor on the falling edge.
module tb_trace_capture;
  localparam int W     = 3;
  localparam int TSW   = 4;
  localparam int DEPTH = 8;
  localparam int TSMAX = (1 << TSW) - 1;
  localparam int SB    = 1024;
`ifdef TRACE_CAPTURE_TS_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         en;
  logic [W-1:0]                 probe;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         overflow;

  trace_capture_if #(.WIDTH(W), .TS_WIDTH(TSW)) bus ();

  trace_capture #(.WIDTH(W), .TS_WIDTH(TSW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .probe    (probe),
    .rd       (bus),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Scoreboard storage: model writes at wr_idx, monitor consumes at rd_idx.
  int      sb_time [SB];
  int      sb_val  [SB];
  int      wr_idx = 0;
  int      rd_idx = 0;
  int      exp_occ = 0;
  bit      exp_ovf = 1'b0;
  bit      done = 1'b0;
  int      tests = 0;
  int      fails = 0;

  // Reference model: an event is the probe value plus edges elapsed since the arm edge.
  bit      armed = 1'b0;
  int      cyc = 0;
  int      arm_cyc = 0;
  int      mprev = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   = 1'b0;
      exp_occ = 0;
      exp_ovf = 1'b0;
      mprev   = 0;
    end else begin
      bit pop_now, push_now, arm_now;
      int raw, t;
      cyc++;
      pop_now  = (exp_occ > 0) && bus.rd_ready;
      push_now = 1'b0;
      arm_now  = 1'b0;
      if (!armed) begin
        if (en) begin
          armed = 1'b1; arm_now = 1'b1; push_now = 1'b1;
          arm_cyc = cyc; mprev = int'(probe); exp_ovf = 1'b0;
        end
      end else if (!en) begin
        armed = 1'b0;
      end else begin
        push_now = (int'(probe) != mprev);
        mprev = int'(probe);
      end
      if (push_now) begin
        raw = cyc - arm_cyc;
        t = SAT ? ((raw > TSMAX) ? TSMAX : raw) : (raw % (TSMAX + 1));
        if (exp_occ < DEPTH || pop_now) begin
          sb_time[wr_idx % SB] = t;
          sb_val[wr_idx % SB]  = int'(probe);
          wr_idx++;
          exp_occ++;
        end else if (!arm_now) begin
          exp_ovf = 1'b1;
        end
      end
      if (pop_now) exp_occ--;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: checks status every cycle and pops the scoreboard on each accepted head.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx = wr_idx;
      #1;
      chk("rst_valid", int'(bus.rd_valid), 0);
      chk("rst_value", int'(bus.rd_value), 0);
      chk("rst_time",  int'(bus.rd_time), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_overflow", int'(overflow), 0);
    end else if (done) begin
      chk("drained", rd_idx, wr_idx);
      chk("final_count", int'(count), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end else begin
      chk("count", int'(count), exp_occ);
      chk("overflow", int'(overflow), int'(exp_ovf));
      chk("rd_valid", int'(bus.rd_valid), int'(exp_occ > 0));
      if (bus.rd_valid && bus.rd_ready) begin
        if (rd_idx == wr_idx) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: got time %0d value %0d, expected no event",
                   bus.rd_time, bus.rd_value);
        end else begin
          chk("rd_time",  int'(bus.rd_time),  sb_time[rd_idx % SB]);
          chk("rd_value", int'(bus.rd_value), sb_val[rd_idx % SB]);
          rd_idx++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && exp_occ > 0; i++) tick();
    tick();
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; probe = '0; bus.rd_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Basic trace: events (0,000) (3,010) (5,100) (7,111)
    en = 1'b1; probe = 3'b000; tick();
    tick(); tick();
    probe = 3'b010; tick();
    tick();
    probe = 3'b100; tick();
    tick();
    probe = 3'b111; tick();
    en = 1'b0; tick();
    drain();

    // Overflow with no reader, then re-arm while still full
    en = 1'b1; probe = 3'b000; tick();
    for (int i = 0; i < 10; i++) begin probe = ~probe; tick(); end
    en = 1'b0; tick();
    en = 1'b1; tick();
    en = 1'b0; tick(); tick();
    drain();

    // Full FIFO with simultaneous push and pop
    en = 1'b1; probe = 3'b001; tick();
    for (int i = 0; i < 7; i++) begin probe = probe ^ 3'b011; tick(); end
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin probe = probe ^ 3'b011; tick(); end
    en = 1'b0; tick();
    drain();

    // Disarm with IDLE activity, then re-arm appending behind unread events
    en = 1'b1; probe = 3'b000; tick();
    probe = 3'b001; tick();
    tick();
    probe = 3'b011; tick();
    en = 1'b0; tick();
    for (int i = 0; i < 5; i++) begin probe = W'($urandom); tick(); end
    en = 1'b1; probe = 3'b110; tick();
    probe = 3'b010; tick();
    en = 1'b0; tick();
    drain();

    // Timestamp limit: change at edge 17 after arm
    bus.rd_ready = 1'b1;
    en = 1'b1; probe = 3'b101; tick();
    repeat (16) tick();
    probe = 3'b010; tick();
    en = 1'b0; tick();
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 2) == 0) probe = W'($urandom);
      bus.rd_ready = (i % 64 < 40) ? ($urandom_range(0, 3) != 0) : 1'b0;
      tick();
    end
    en = 1'b0; tick();
    drain();

    // Asynchronous reset in mid-capture with three events buffered
    en = 1'b1; probe = 3'b000; tick();
    probe = 3'b001; tick();
    probe = 3'b010; tick();
    @(posedge clk); #2;
    rst_n = 1'b0; en = 1'b0;
    #6;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin probe = W'(i + 3); tick(); end
    en = 1'b1; probe = 3'b111; tick();
    probe = 3'b100; tick();
    en = 1'b0; tick();
    drain();

    done = 1'b1;
  end
endmodule
